// File: rtl/chunked_seq_adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg: shared types and helpers for the chunked sequential adder.
//   state_e   : controller states (IDLE, RUN, DONE)
//   mode_e    : operation select (ADD = 0, SUB = 1)
//   idx_width : bit width of the chunk index counter for a given chunk count
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Counter must be at least one bit wide even when a single chunk covers the word.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? 32'($clog2(nchunk)) : 32'd1;
  endfunction

endpackage : adder_pkg

// File: rtl/chunked_seq_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder_if: request/response bundle of the chunked sequential adder.
//   Request  (master -> slave): in_valid, a, b, cin, mode, out_ready
//   Response (slave -> master): in_ready, out_valid, sum, cout, ovf
//   master modport: producer/consumer side; slave modport: adder side.
// ---------------------------------------------------------------------------
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface : chunked_seq_adder_if

// File: rtl/chunked_seq_adder_chunk_add.sv
// ---------------------------------------------------------------------------
// chunk_add: combinational CHUNK-bit ripple adder built from full-adder cells.
//   a, b     : chunk operands
//   cin      : carry into bit 0
//   sum_c    : chunk sum
//   cout_c   : carry out of bit CHUNK-1
//   c_msb_c  : carry into bit CHUNK-1 (overflow detection on the top chunk)
// ---------------------------------------------------------------------------
module chunk_add #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_c,
  output logic             cout_c,
  output logic             c_msb_c
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum_c[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c  = carry[CHUNK];
  assign c_msb_c = carry[CHUNK-1];

endmodule : chunk_add

// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder: multi-cycle WIDTH-bit adder/subtractor that processes
// CHUNK bits per clock, LSB chunk first, with the carry held in a register.
// One operation in flight; valid/ready on both request and result side.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.slave  : in_valid/in_ready/a/b/cin/mode request,
//                out_valid/out_ready/sum/cout/ovf result (all outputs registered)
// ---------------------------------------------------------------------------
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  chunked_seq_adder_if.slave bus
);

  import adder_pkg::*;

  localparam int unsigned CHUNK_SAFE = (CHUNK < 1) ? 32'd1 : CHUNK;
  localparam int unsigned NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int unsigned IDXW       = idx_width(NCHUNK);

  // Reject parameter sets that do not tile the word into whole chunks.
  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
    $error("chunked_seq_adder: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  state_e                         state_q, state_d;
  logic [IDXW-1:0]                idx_q, idx_d;
  logic                           carry_q, carry_d;
  logic [NCHUNK-1:0][CHUNK-1:0]   a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0]   b_q, b_d;
  logic [NCHUNK-1:0][CHUNK-1:0]   sum_q, sum_d;
  logic                           cout_q, cout_d;
  logic                           ovf_q, ovf_d;
  logic                           out_valid_q, out_valid_d;
  logic                           in_ready_q, in_ready_d;

  logic [CHUNK-1:0]               chunk_sum_c;
  logic                           chunk_cout_c;
  logic                           chunk_cmsb_c;
  logic                           is_sub_c;
  logic                           last_chunk_c;

  assign is_sub_c     = (mode_e'(bus.mode) == SUB);
  assign last_chunk_c = (idx_q == IDXW'(NCHUNK - 1));

  // Datapath: the chunk selected by the index counter.
  chunk_add #(
    .CHUNK (CHUNK_SAFE)
  ) u_chunk_add (
    .a       (a_q[idx_q]),
    .b       (b_q[idx_q]),
    .cin     (carry_q),
    .sum_c   (chunk_sum_c),
    .cout_c  (chunk_cout_c),
    .c_msb_c (chunk_cmsb_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Subtraction is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
          a_d        = bus.a;
          b_d        = is_sub_c ? ~bus.b : bus.b;
          carry_d    = is_sub_c ? ~bus.cin : bus.cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        sum_d[idx_q] = chunk_sum_c;
        carry_d      = chunk_cout_c;
        if (last_chunk_c) begin
          cout_d      = chunk_cout_c;
          ovf_d       = chunk_cout_c ^ chunk_cmsb_c;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule : chunked_seq_adder

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder: directed bench for chunked_seq_adder.
// A 32/4 instance covers latency, arithmetic corners, backpressure and reset
// abort; a 4/4 instance is swept over all operand/carry/mode combinations.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(32)) bus32 ();
  chunked_seq_adder_if #(.WIDTH(4))  bus4 ();

  chunked_seq_adder #(.WIDTH(32), .CHUNK(4)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  chunked_seq_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted, then scramble the inputs.
  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic mode);
    bus32.a        = a;
    bus32.b        = b;
    bus32.cin      = cin;
    bus32.mode     = mode;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.a        = 32'hDEAD_BEEF;
    bus32.b        = 32'hCAFE_F00D;
    bus32.cin      = ~cin;
    bus32.mode     = ~mode;
    chk("accept in_ready low", 32'(bus32.in_ready), 32'd0);
  endtask

  task automatic wait32(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus32.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait4(output int lat);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus4.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic handshake32(input string tag);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(bus32.out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(bus32.in_ready), 32'd1);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic mode, input logic [31:0] exp_sum,
                      input logic exp_cout, input logic exp_ovf);
    int lat;
    start32(a, b, cin, mode);
    wait32(lat);
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " sum"}, bus32.sum, exp_sum);
    chk({tag, " cout"}, 32'(bus32.cout), 32'(exp_cout));
    chk({tag, " ovf"}, 32'(bus32.ovf), 32'(exp_ovf));
    handshake32(tag);
  endtask

  initial begin
    int          lat;
    int          full;
    int          bp;
    logic [3:0]  av, bv, es;
    logic        ec, eo;

    rst_n           = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.cin       = 1'b0;
    bus32.mode      = 1'b0;
    bus32.out_ready = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.a          = '0;
    bus4.b          = '0;
    bus4.cin        = 1'b0;
    bus4.mode       = 1'b0;
    bus4.out_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus32.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus32.out_valid), 32'd0);
    chk("reset sum", bus32.sum, 32'd0);
    chk("reset cout", 32'(bus32.cout), 32'd0);
    chk("reset ovf", 32'(bus32.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op32("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    op32("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op32("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    op32("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op32("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op32("add_cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    op32("sub_borrow", 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op32("sub_zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Result held under backpressure while a new request waits.
    start32(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
    wait32(lat);
    chk("hold latency", 32'(lat), 32'd8);
    bus32.a        = 32'h8000_0000;
    bus32.b        = 32'h8000_0000;
    bus32.cin      = 1'b0;
    bus32.mode     = 1'b0;
    bus32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(bus32.out_valid), 32'd1);
      chk("hold in_ready", 32'(bus32.in_ready), 32'd0);
      chk("hold sum", bus32.sum, 32'hFFFF_FFFF);
      chk("hold cout", 32'(bus32.cout), 32'd0);
      chk("hold ovf", 32'(bus32.ovf), 32'd0);
    end
    handshake32("hold");
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    chk("b2b accepted", 32'(bus32.in_ready), 32'd0);
    wait32(lat);
    chk("b2b latency", 32'(lat), 32'd8);
    chk("b2b sum", bus32.sum, 32'h0000_0000);
    chk("b2b cout", 32'(bus32.cout), 32'd1);
    chk("b2b ovf", 32'(bus32.ovf), 32'd1);
    handshake32("b2b");

    // Reset while chunk 3 is being computed.
    start32(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("partial sum", bus32.sum, 32'h0000_0333);
    chk("partial out_valid", 32'(bus32.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus32.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus32.in_ready), 32'd1);
    chk("abort sum", bus32.sum, 32'd0);
    chk("abort cout", 32'(bus32.cout), 32'd0);
    chk("abort ovf", 32'(bus32.ovf), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("in reset out_valid", 32'(bus32.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset out_valid", 32'(bus32.out_valid), 32'd0);
    op32("post_reset", 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0FFF, 1'b1, 1'b0);

    // Single-chunk instance: every operand, carry and mode combination.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          for (int m = 0; m < 2; m++) begin
            av = 4'(a);
            bv = 4'(b);
            if (m == 0) begin
              full = a + b + c;
              es   = 4'(full);
              ec   = (full > 15);
              eo   = (av[3] == bv[3]) && (es[3] != av[3]);
            end else begin
              full = a - b - c;
              es   = 4'(full);
              ec   = (full >= 0);
              eo   = (av[3] != bv[3]) && (es[3] != av[3]);
            end
            bus4.a        = av;
            bus4.b        = bv;
            bus4.cin      = 1'(c);
            bus4.mode     = 1'(m);
            bus4.in_valid = 1'b1;
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            bus4.cin      = ~bus4.cin;
            bus4.mode     = ~bus4.mode;
            wait4(lat);
            chk($sformatf("x4 a=%0d b=%0d c=%0d m=%0d latency", a, b, c, m), 32'(lat), 32'd1);
            bp = int'($urandom_range(0, 2));
            for (int k = 0; k < bp; k++) begin
              @(posedge clk); #1;
              chk($sformatf("x4 a=%0d b=%0d c=%0d m=%0d held", a, b, c, m),
                  32'(bus4.out_valid), 32'd1);
            end
            chk($sformatf("x4 a=%0d b=%0d c=%0d m=%0d sum", a, b, c, m), 32'(bus4.sum), 32'(es));
            chk($sformatf("x4 a=%0d b=%0d c=%0d m=%0d cout", a, b, c, m), 32'(bus4.cout), 32'(ec));
            chk($sformatf("x4 a=%0d b=%0d c=%0d m=%0d ovf", a, b, c, m), 32'(bus4.ovf), 32'(eo));
            bus4.out_ready = 1'b1;
            @(posedge clk); #1;
            bus4.out_ready = 1'b0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_chunked_seq_adder
